// File: rtl/err_fault_latch_if.sv
// Bundles the error inputs, clear/count-clear requests and latched status
// outputs of err_fault_latch. The master side drives the inputs.
interface err_fault_latch_if #(
    parameter int NCH   = 4,
    parameter int IDX_W = 2,
    parameter int CNT_W = 8
);
    logic                   time_1us;
    logic [NCH-1:0]         err_in;
    logic [NCH-1:0]         enable_mask;
    logic                   clr_req;
    logic                   cnt_clr;
    logic                   trip;
    logic [NCH-1:0]         fault_flags;
    logic [IDX_W-1:0]       first_fault;
    logic                   first_valid;
    logic                   clr_ack;
    logic                   clr_rej;
    logic [NCH*CNT_W-1:0]   evt_cnt;

    modport master (
        output time_1us, err_in, enable_mask, clr_req, cnt_clr,
        input  trip, fault_flags, first_fault, first_valid, clr_ack, clr_rej, evt_cnt
    );

    modport slave (
        input  time_1us, err_in, enable_mask, clr_req, cnt_clr,
        output trip, fault_flags, first_fault, first_valid, clr_ack, clr_rej, evt_cnt
    );
endinterface

// File: rtl/err_fault_latch.sv
// Latches debounced error lines into a maskable trip with first-fault capture,
// a minimum hold time in microsecond ticks, a clear handshake and event counters.
module err_fault_latch #(
    parameter int NCH     = 4,
    parameter int IDX_W   = 2,
    parameter int CNT_W   = 8,
    parameter int HOLD_US = 100
) (
    input  logic              clk,
    input  logic              reset_unit,
    err_fault_latch_if.slave  bus
);

    typedef enum logic [1:0] {
        ARMED    = 2'd0,
        TRIPPED  = 2'd1,
        WAIT_CLR = 2'd2
    } state_t;

    localparam logic [15:0] HOLD_INIT = 16'(HOLD_US);

    state_t             state;
    state_t             state_n;
    logic [NCH-1:0]     err_q;
    logic [NCH-1:0]     rise;
    logic [NCH-1:0]     active;
    logic [1:0]         ts;
    logic               tick;
    logic [15:0]        hold;
    logic [15:0]        hold_n;
    logic [IDX_W-1:0]   low_idx;

    logic               trip_r;
    logic               trip_n;
    logic [NCH-1:0]     flags_r;
    logic [NCH-1:0]     flags_n;
    logic [IDX_W-1:0]   first_r;
    logic [IDX_W-1:0]   first_n;
    logic               fv_r;
    logic               fv_n;
    logic               ack_r;
    logic               ack_n;
    logic               rej_r;
    logic               rej_n;

    assign rise   = bus.err_in & ~err_q & bus.enable_mask;
    assign active = bus.err_in & bus.enable_mask;
    // ts[1] is the older sample, so 2'b10 marks a falling edge of time_1us.
    assign tick   = (ts == 2'b10);

    always_ff @(posedge clk) begin
        if (reset_unit) begin
            err_q <= '0;
            ts    <= 2'b00;
        end else begin
            err_q <= bus.err_in;
            ts    <= {ts[0], bus.time_1us};
        end
    end

    always_comb begin
        low_idx = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (rise[i]) begin
                low_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_unit) begin
            state <= ARMED;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        hold_n  = hold;
        trip_n  = trip_r;
        flags_n = flags_r | rise;
        first_n = first_r;
        fv_n    = fv_r;
        ack_n   = 1'b0;
        rej_n   = 1'b0;
        case (state)
            ARMED: begin
                if (|rise) begin
                    state_n = TRIPPED;
                    trip_n  = 1'b1;
                    first_n = low_idx;
                    fv_n    = 1'b1;
                    hold_n  = HOLD_INIT;
                end
            end
            TRIPPED: begin
                if (hold == 16'd0) begin
                    state_n = WAIT_CLR;
                end else if (tick) begin
                    hold_n = hold - 16'd1;
                end
            end
            WAIT_CLR: begin
                // A still-asserted enabled line (including a fresh rise) blocks the clear.
                if (bus.clr_req) begin
                    if (|active) begin
                        rej_n = 1'b1;
                    end else begin
                        state_n = ARMED;
                        trip_n  = 1'b0;
                        flags_n = '0;
                        first_n = '0;
                        fv_n    = 1'b0;
                        ack_n   = 1'b1;
                    end
                end
            end
            default: begin
                state_n = ARMED;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_unit) begin
            hold    <= '0;
            trip_r  <= 1'b0;
            flags_r <= '0;
            first_r <= '0;
            fv_r    <= 1'b0;
            ack_r   <= 1'b0;
            rej_r   <= 1'b0;
        end else begin
            hold    <= hold_n;
            trip_r  <= trip_n;
            flags_r <= flags_n;
            first_r <= first_n;
            fv_r    <= fv_n;
            ack_r   <= ack_n;
            rej_r   <= rej_n;
        end
    end

    assign bus.trip        = trip_r;
    assign bus.fault_flags = flags_r;
    assign bus.first_fault = first_r;
    assign bus.first_valid = fv_r;
    assign bus.clr_ack     = ack_r;
    assign bus.clr_rej     = rej_r;

    // Counters run in every state and saturate; cnt_clr wins over a same-cycle rise.
    for (genvar g = 0; g < NCH; g++) begin : g_cnt
        logic [CNT_W-1:0] count;

        always_ff @(posedge clk) begin
            if (reset_unit || bus.cnt_clr) begin
                count <= '0;
            end else if (rise[g] && (count != {CNT_W{1'b1}})) begin
                count <= count + 1'b1;
            end
        end

        assign bus.evt_cnt[g*CNT_W +: CNT_W] = count;
    end

endmodule

// File: tb/tb_err_fault_latch.sv
// Self-checking bench for err_fault_latch: directed vector table, hand-written
// sequences, then randomized traffic against a behavioural model.
module tb_err_fault_latch;

    localparam int NCH   = 4;
    localparam int IDX_W = 2;
    localparam int CNT_W = 8;
    localparam int HOLD  = 3;

    logic clk;
    logic reset_unit;

    int tests_run;
    int tests_failed;

    err_fault_latch_if #(.NCH(NCH), .IDX_W(IDX_W), .CNT_W(CNT_W)) bus ();

    err_fault_latch #(
        .NCH(NCH), .IDX_W(IDX_W), .CNT_W(CNT_W), .HOLD_US(HOLD)
    ) dut (
        .clk(clk),
        .reset_unit(reset_unit),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  err;
        logic [3:0]  mask;
        logic        clr;
        logic        cclr;
        logic        t;
        logic        exp_trip;
        logic [3:0]  exp_flags;
        logic [1:0]  exp_first;
        logic        exp_fv;
        logic        exp_ack;
        logic        exp_rej;
        logic [31:0] exp_cnt;
    } vec_t;

    vec_t vecs[$];

    // Behavioural reference: phase 0 = idle, 1 = holding, 2 = awaiting clear.
    int       m_phase;
    bit       m_trip;
    bit [3:0] m_flags;
    int       m_first;
    bit       m_fv;
    bit       m_ack;
    bit       m_rej;
    int       m_hold_left;
    int       m_cnt[4];
    bit [3:0] m_prev;
    bit       m_t_new;
    bit       m_t_old;

    function automatic vec_t mkvec(logic rst, logic [3:0] err, logic [3:0] mask,
                                   logic clr, logic cclr, logic t,
                                   logic e_trip, logic [3:0] e_flags, logic [1:0] e_first,
                                   logic e_fv, logic e_ack, logic e_rej, logic [31:0] e_cnt);
        vec_t v;
        v.rst = rst; v.err = err; v.mask = mask; v.clr = clr; v.cclr = cclr; v.t = t;
        v.exp_trip = e_trip; v.exp_flags = e_flags; v.exp_first = e_first;
        v.exp_fv = e_fv; v.exp_ack = e_ack; v.exp_rej = e_rej; v.exp_cnt = e_cnt;
        return v;
    endfunction

    task automatic model_step();
        bit [3:0] rise;
        bit [3:0] lsb;
        bit       tick;
        if (reset_unit) begin
            m_phase = 0; m_trip = 0; m_flags = 0; m_first = 0; m_fv = 0;
            m_ack = 0; m_rej = 0; m_hold_left = 0; m_prev = 0;
            m_t_new = 0; m_t_old = 0;
            for (int i = 0; i < 4; i++) m_cnt[i] = 0;
            return;
        end
        rise  = bus.err_in & ~m_prev & bus.enable_mask;
        tick  = m_t_old && !m_t_new;
        m_ack = 0;
        m_rej = 0;
        m_flags = m_flags | rise;
        if (m_phase == 0) begin
            if (rise != 0) begin
                lsb         = rise & (~rise + 4'd1);
                m_phase     = 1;
                m_trip      = 1;
                m_fv        = 1;
                m_first     = $clog2(lsb);
                m_hold_left = HOLD;
            end
        end else if (m_phase == 1) begin
            if (m_hold_left == 0) m_phase = 2;
            else if (tick) m_hold_left = m_hold_left - 1;
        end else if (bus.clr_req) begin
            if ((bus.err_in & bus.enable_mask) != 0) begin
                m_rej = 1;
            end else begin
                m_phase = 0; m_trip = 0; m_flags = 0; m_first = 0; m_fv = 0; m_ack = 1;
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (bus.cnt_clr) m_cnt[i] = 0;
            else if (rise[i]) m_cnt[i] = (m_cnt[i] + 1 > 255) ? 255 : m_cnt[i] + 1;
        end
        m_t_old = m_t_new;
        m_t_new = bus.time_1us;
        m_prev  = bus.err_in;
    endtask

    task automatic applyStimulus(logic rst, logic [3:0] err, logic [3:0] mask,
                                 logic clr, logic cclr, logic t);
        reset_unit      = rst;
        bus.err_in      = err;
        bus.enable_mask = mask;
        bus.clr_req     = clr;
        bus.cnt_clr     = cclr;
        bus.time_1us    = t;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic checkOutput(string name, logic [63:0] act, logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model_pack();
        logic [31:0] c;
        for (int i = 0; i < 4; i++) c[i*8 +: 8] = 8'(m_cnt[i]);
        return {22'd0, m_trip, m_flags, 2'(m_first), m_fv, m_ack, m_rej, c};
    endfunction

    function automatic logic [63:0] dut_pack();
        return {22'd0, bus.trip, bus.fault_flags, bus.first_fault, bus.first_valid,
                bus.clr_ack, bus.clr_rej, bus.evt_cnt};
    endfunction

    initial begin
        logic [3:0] err;
        logic [3:0] mask;

        tests_run    = 0;
        tests_failed = 0;
        reset_unit      = 1'b1;
        bus.err_in      = '0;
        bus.enable_mask = '1;
        bus.clr_req     = 1'b0;
        bus.cnt_clr     = 1'b0;
        bus.time_1us    = 1'b0;

        //                   rst err   mask  clr cclr t    trip flags first fv ack rej cnt
        vecs.push_back(mkvec(1, 4'h0, 4'hF, 0, 0, 0,   0, 4'h0, 0, 0, 0, 0, 32'h0000_0000));
        vecs.push_back(mkvec(0, 4'h0, 4'hF, 0, 0, 0,   0, 4'h0, 0, 0, 0, 0, 32'h0000_0000));
        vecs.push_back(mkvec(0, 4'h4, 4'hF, 0, 0, 0,   1, 4'h4, 2, 1, 0, 0, 32'h0001_0000));
        vecs.push_back(mkvec(0, 4'h4, 4'hF, 1, 0, 0,   1, 4'h4, 2, 1, 0, 0, 32'h0001_0000));
        vecs.push_back(mkvec(0, 4'h4, 4'hF, 0, 0, 1,   1, 4'h4, 2, 1, 0, 0, 32'h0001_0000));
        vecs.push_back(mkvec(0, 4'h4, 4'hF, 0, 0, 0,   1, 4'h4, 2, 1, 0, 0, 32'h0001_0000));
        vecs.push_back(mkvec(0, 4'h4, 4'hF, 0, 0, 1,   1, 4'h4, 2, 1, 0, 0, 32'h0001_0000));
        vecs.push_back(mkvec(0, 4'h4, 4'hF, 0, 0, 0,   1, 4'h4, 2, 1, 0, 0, 32'h0001_0000));
        vecs.push_back(mkvec(0, 4'h4, 4'hF, 1, 0, 1,   1, 4'h4, 2, 1, 0, 0, 32'h0001_0000));
        vecs.push_back(mkvec(0, 4'h4, 4'hF, 0, 0, 0,   1, 4'h4, 2, 1, 0, 0, 32'h0001_0000));
        vecs.push_back(mkvec(0, 4'h4, 4'hF, 0, 0, 0,   1, 4'h4, 2, 1, 0, 0, 32'h0001_0000));
        vecs.push_back(mkvec(0, 4'h4, 4'hF, 0, 0, 0,   1, 4'h4, 2, 1, 0, 0, 32'h0001_0000));
        vecs.push_back(mkvec(0, 4'h4, 4'hF, 1, 0, 0,   1, 4'h4, 2, 1, 0, 1, 32'h0001_0000));
        vecs.push_back(mkvec(0, 4'h4, 4'hF, 0, 0, 0,   1, 4'h4, 2, 1, 0, 0, 32'h0001_0000));
        vecs.push_back(mkvec(0, 4'h0, 4'hF, 0, 0, 0,   1, 4'h4, 2, 1, 0, 0, 32'h0001_0000));
        vecs.push_back(mkvec(0, 4'h0, 4'hF, 1, 0, 0,   0, 4'h0, 0, 0, 1, 0, 32'h0001_0000));
        vecs.push_back(mkvec(0, 4'h0, 4'hF, 0, 0, 0,   0, 4'h0, 0, 0, 0, 0, 32'h0001_0000));
        vecs.push_back(mkvec(0, 4'hA, 4'hF, 0, 0, 0,   1, 4'hA, 1, 1, 0, 0, 32'h0101_0100));
        vecs.push_back(mkvec(0, 4'hB, 4'hF, 0, 0, 0,   1, 4'hB, 1, 1, 0, 0, 32'h0101_0101));
        vecs.push_back(mkvec(0, 4'hB, 4'hF, 0, 1, 0,   1, 4'hB, 1, 1, 0, 0, 32'h0000_0000));
        vecs.push_back(mkvec(1, 4'h2, 4'hF, 0, 0, 0,   0, 4'h0, 0, 0, 0, 0, 32'h0000_0000));
        vecs.push_back(mkvec(1, 4'h2, 4'hF, 0, 0, 0,   0, 4'h0, 0, 0, 0, 0, 32'h0000_0000));
        vecs.push_back(mkvec(0, 4'h2, 4'hF, 0, 0, 0,   1, 4'h2, 1, 1, 0, 0, 32'h0000_0100));

        for (int k = 0; k < vecs.size(); k++) begin
            applyStimulus(vecs[k].rst, vecs[k].err, vecs[k].mask,
                          vecs[k].clr, vecs[k].cclr, vecs[k].t);
            checkOutput($sformatf("vec%0d trip", k),  64'(bus.trip),        64'(vecs[k].exp_trip));
            checkOutput($sformatf("vec%0d flags", k), 64'(bus.fault_flags), 64'(vecs[k].exp_flags));
            checkOutput($sformatf("vec%0d first", k), 64'(bus.first_fault), 64'(vecs[k].exp_first));
            checkOutput($sformatf("vec%0d valid", k), 64'(bus.first_valid), 64'(vecs[k].exp_fv));
            checkOutput($sformatf("vec%0d ack", k),   64'(bus.clr_ack),     64'(vecs[k].exp_ack));
            checkOutput($sformatf("vec%0d rej", k),   64'(bus.clr_rej),     64'(vecs[k].exp_rej));
            checkOutput($sformatf("vec%0d cnt", k),   64'(bus.evt_cnt),     64'(vecs[k].exp_cnt));
        end

        // Masked channel toggling must neither trip nor count.
        applyStimulus(1, 4'h0, 4'h7, 0, 0, 0);
        for (int k = 0; k < 10; k++) begin
            applyStimulus(0, 4'h8, 4'h7, 0, 0, 0);
            applyStimulus(0, 4'h0, 4'h7, 0, 0, 0);
        end
        checkOutput("masked trip", 64'(bus.trip), 64'd0);
        checkOutput("masked cnt3", 64'(bus.evt_cnt[31:24]), 64'd0);

        // Counter saturation on channel 0.
        for (int k = 0; k < 300; k++) begin
            applyStimulus(0, 4'h1, 4'hF, 0, 0, 0);
            applyStimulus(0, 4'h0, 4'hF, 0, 0, 0);
        end
        checkOutput("sat cnt0", 64'(bus.evt_cnt[7:0]), 64'd255);
        checkOutput("sat first", 64'({bus.trip, bus.first_fault, bus.first_valid}), 64'b1001);

        // cnt_clr coincident with a rise leaves the counter at zero.
        applyStimulus(0, 4'h1, 4'hF, 0, 1, 0);
        checkOutput("cntclr vs rise", 64'(bus.evt_cnt), 64'd0);

        // Randomized traffic against the model.
        applyStimulus(1, 4'h0, 4'hF, 0, 0, 0);
        err  = 4'h0;
        mask = 4'hF;
        for (int k = 0; k < 1500; k++) begin
            for (int b = 0; b < 4; b++) begin
                if (err[b]) begin
                    if ($urandom_range(2) == 0) err[b] = 1'b0;
                end else begin
                    if ($urandom_range(9) == 0) err[b] = 1'b1;
                end
            end
            if ($urandom_range(19) == 0) mask = ($urandom_range(3) == 0) ? 4'(($urandom_range(15))) : 4'hF;
            applyStimulus(($urandom_range(127) == 0), err, mask,
                          ($urandom_range(3) == 0), ($urandom_range(49) == 0),
                          1'($urandom_range(1)));
            checkOutput($sformatf("rand%0d", k), dut_pack(), model_pack());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
